ins_decode_seq: RTL and testbench

- Registered, multi-cycle successor to the combinational instruction decoder for the teaching CPU.
- Accepts an instruction word over a valid/ready handshake, decodes the top 8 bits into one-hot control lines, holds them for an opcode-dependent number of execute steps, then returns to accept the next instruction.
- Adds a halt state with resume, conditional-jump resolution, illegal-opcode flagging and an operand field for wider instruction words.
- Sits between the instruction register and the datapath control.

---
 rtl/ins_decode_seq.sv | 162 ++++++++++++++++
 tb/tb_ins_decode_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ins_decode_seq.sv
// Multi-cycle instruction decoder: accepts a word over valid/ready, holds one-hot
// controls for 1 or 2 execute steps, with halt/resume and illegal-opcode counting.
module ins_decode_seq #(
  parameter int IR_W   = 8,
  parameter int STEP_W = 2,
  parameter int ERR_W  = 8,
  localparam int OPND_W = (IR_W > 8) ? IR_W - 8 : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_valid,
  output logic              ir_ready,
  input  logic [IR_W-1:0]   ir,
  input  logic              flag_g,
  input  logic              resume,
  output logic              mova,
  output logic              movb,
  output logic              movc,
  output logic              movd,
  output logic              movi,
  output logic              add,
  output logic              sub,
  output logic              jmp,
  output logic              jg,
  output logic              in1,
  output logic              out1,
  output logic              jg_taken,
  output logic [OPND_W-1:0] opnd,
  output logic [STEP_W-1:0] step,
  output logic              done,
  output logic              halted,
  output logic              illegal,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HALT} state_e;

  localparam int B_MOVA = 0, B_MOVB = 1, B_MOVC = 2, B_MOVD = 3, B_MOVI = 4, B_ADD = 5;
  localparam int B_SUB = 6, B_JMP = 7, B_JG = 8, B_IN1 = 9, B_OUT1 = 10;

  state_e              state_q, state_d;
  logic [10:0]         ctrl_q, ctrl_d;
  logic                jgt_q, jgt_d;
  logic [OPND_W-1:0]   opnd_q, opnd_d, opnd_in;
  logic [STEP_W-1:0]   step_q, step_d, last_q, last_d;
  logic                ill_q, ill_d;
  logic [ERR_W-1:0]    err_q, err_d;

  logic [7:0]          op;
  logic [10:0]         dec_ctrl;
  logic                dec_two, dec_halt, dec_ill;

  assign op = ir[IR_W-1 -: 8];

  if (IR_W > 8) begin : g_opnd
    assign opnd_in = ir[IR_W-9:0];
  end else begin : g_no_opnd
    assign opnd_in = 1'b0;
  end

  // Priority decode of the opcode byte; first matching pattern wins.
  always_comb begin
    dec_ctrl = '0;
    dec_two  = 1'b0;
    dec_halt = 1'b0;
    dec_ill  = 1'b0;
    casez (op)
      8'b0100_????: dec_ctrl[B_MOVA] = 1'b1;
      8'b0101_00??: dec_ctrl[B_MOVB] = 1'b1;
      8'b0110_????: dec_ctrl[B_MOVC] = 1'b1;
      8'b0111_11??: dec_ctrl[B_MOVD] = 1'b1;
      8'b1000_????: begin dec_ctrl[B_ADD]  = 1'b1; dec_two = 1'b1; end
      8'b1001_????: begin dec_ctrl[B_SUB]  = 1'b1; dec_two = 1'b1; end
      8'b1010_????: dec_ctrl[B_JMP] = 1'b1;
      8'b1011_????: dec_ctrl[B_JG]  = 1'b1;
      8'b1100_????: begin dec_ctrl[B_IN1]  = 1'b1; dec_two = 1'b1; end
      8'b1101_????: begin dec_ctrl[B_OUT1] = 1'b1; dec_two = 1'b1; end
      8'b1110_00??: begin dec_ctrl[B_MOVI] = 1'b1; dec_two = 1'b1; end
      8'b1111_0000: dec_halt = 1'b1;
      default:      dec_ill  = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    jgt_d   = jgt_q;
    opnd_d  = opnd_q;
    step_d  = step_q;
    last_d  = last_q;
    ill_d   = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (ir_valid) begin
          if (dec_ill) begin
            ill_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
          end else if (dec_halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_EXEC;
            ctrl_d  = dec_ctrl;
            jgt_d   = dec_ctrl[B_JG] & flag_g;
            opnd_d  = opnd_in;
            step_d  = '0;
            last_d  = dec_two ? STEP_W'(1) : '0;
          end
        end
      end
      S_EXEC: begin
        if (step_q == last_q) begin
          state_d = S_IDLE;
          ctrl_d  = '0;
          jgt_d   = 1'b0;
          opnd_d  = '0;
          step_d  = '0;
          last_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_HALT: begin
        if (resume) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      jgt_q   <= 1'b0;
      opnd_q  <= '0;
      step_q  <= '0;
      last_q  <= '0;
      ill_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      jgt_q   <= jgt_d;
      opnd_q  <= opnd_d;
      step_q  <= step_d;
      last_q  <= last_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

  assign ir_ready = (state_q == S_IDLE);
  assign halted   = (state_q == S_HALT);
  assign done     = (state_q == S_EXEC) && (step_q == last_q);
  assign {out1, in1, jg, jmp, sub, add, movi, movd, movc, movb, mova} = ctrl_q;
  assign jg_taken = jgt_q;
  assign opnd     = opnd_q;
  assign step     = step_q;
  assign illegal  = ill_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_ins_decode_seq.sv
// Scoreboard bench for ins_decode_seq (12-bit words, 2-bit error counter):
// a table-driven transaction model predicts events that a monitor checks.
module tb_ins_decode_seq;
  localparam int IR_W = 12, STEP_W = 2, ERR_W = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic ir_valid = 1'b0, flag_g = 1'b0, resume = 1'b0;
  logic [IR_W-1:0] ir = '0;
  logic ir_ready, mova, movb, movc, movd, movi, add, sub, jmp, jg, in1, out1;
  logic jg_taken, done, halted, illegal;
  logic [3:0] opnd;
  logic [STEP_W-1:0] step;
  logic [ERR_W-1:0] err_cnt;

  always #5 clk = ~clk;

  ins_decode_seq #(.IR_W(IR_W), .STEP_W(STEP_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
    .flag_g(flag_g), .resume(resume), .mova(mova), .movb(movb), .movc(movc),
    .movd(movd), .movi(movi), .add(add), .sub(sub), .jmp(jmp), .jg(jg),
    .in1(in1), .out1(out1), .jg_taken(jg_taken), .opnd(opnd), .step(step),
    .done(done), .halted(halted), .illegal(illegal), .err_cnt(err_cnt)
  );

  wire [10:0] ctl = {out1, in1, jg, jmp, sub, add, movi, movd, movc, movb, mova};

  int nchecks = 0, nerrs = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode table: mask/value pattern, control bit (-1 = halt), execute steps.
  logic [7:0] t_mask [12] = '{8'hF0, 8'hFC, 8'hF0, 8'hFC, 8'hF0, 8'hF0,
                              8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hFC, 8'hFF};
  logic [7:0] t_val  [12] = '{8'h40, 8'h50, 8'h60, 8'h7C, 8'h80, 8'h90,
                              8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
  int t_bit   [12] = '{0, 1, 2, 3, 5, 6, 7, 8, 9, 10, 4, -1};
  int t_steps [12] = '{1, 1, 1, 1, 2, 2, 1, 1, 2, 2, 2, 0};

  function automatic int ref_decode(logic [7:0] o);
    for (int i = 0; i < 12; i++)
      if ((o & t_mask[i]) == t_val[i]) return i;
    return -1;
  endfunction

  typedef struct {
    bit         is_exec;
    logic [10:0] ctrl;
    logic       jgt;
    logic [3:0] opnd;
    int         steps;
    int         acc;
    int         err;
  } item_t;

  item_t sb[$];
  item_t it, pt, m_cur;
  int m_state, m_step, m_err, cyc, k;
  bit m_ill;

  // Transaction-level model: 0 = idle, 1 = executing, 2 = halted.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_step = 0; m_err = 0; m_ill = 0;
      m_cur = '{default: 0};
      sb.delete();
    end else begin
      cyc++;
      m_ill = 0;
      case (m_state)
        0: if (ir_valid) begin
          k = ref_decode(ir[11:4]);
          if (k < 0) begin
            if (m_err < ERR_MAX) m_err++;
            m_ill = 1;
            it = '{default: 0};
            it.err = m_err;
            sb.push_back(it);
          end else if (t_bit[k] < 0) begin
            m_state = 2;
          end else begin
            it.is_exec = 1;
            it.ctrl    = 11'(1) << t_bit[k];
            it.jgt     = (t_bit[k] == 8) && flag_g;
            it.opnd    = ir[3:0];
            it.steps   = t_steps[k];
            it.acc     = cyc;
            it.err     = m_err;
            sb.push_back(it);
            m_cur = it; m_step = 0; m_state = 1;
          end
        end
        1: if (m_step == m_cur.steps - 1) m_state = 0; else m_step++;
        default: if (resume) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ir_ready", ir_ready, m_state == 0);
      chk("halted", halted, m_state == 2);
      chk("controls", ctl, (m_state == 1) ? m_cur.ctrl : 11'd0);
      chk("jg_taken", jg_taken, (m_state == 1) ? m_cur.jgt : 1'b0);
      chk("opnd", opnd, (m_state == 1) ? m_cur.opnd : 4'd0);
      chk("step", step, (m_state == 1) ? m_step : 0);
      chk("done", done, (m_state == 1) && (m_step == m_cur.steps - 1));
      chk("illegal", illegal, m_ill);
      chk("err_cnt", err_cnt, m_err);
      if (done || illegal) begin
        chk("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          pt = sb.pop_front();
          chk("event_kind", done, pt.is_exec);
          if (pt.is_exec) begin
            chk("done_ctrl", ctl, pt.ctrl);
            chk("done_jg_taken", jg_taken, pt.jgt);
            chk("done_opnd", opnd, pt.opnd);
            chk("done_latency", cyc - pt.acc, pt.steps - 1);
          end else begin
            chk("ill_err_cnt", err_cnt, pt.err);
            chk("ill_no_ctrl", ctl, 11'd0);
          end
        end
      end
    end
  end

  task automatic drive(bit v, logic [IR_W-1:0] w, bit f, bit r);
    @(negedge clk);
    ir_valid = v; ir = w; flag_g = f; resume = r;
  endtask

  logic [7:0] op;
  int sel;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", ctl, 11'd0);
    chk("rst_done", done, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_step", step, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("ready_after_rst", ir_ready, 1);

    repeat (4) drive(1, 12'h40A, 0, 0);          // mova held valid
    drive(1, 12'h853, 0, 0);                     // add, two steps
    repeat (3) drive(0, 12'h000, 0, 0);
    drive(1, 12'hB07, 1, 0);                     // jg taken, flag drops afterwards
    repeat (2) drive(0, 12'h000, 0, 0);
    drive(1, 12'hB01, 0, 0);                     // jg not taken, flag rises afterwards
    repeat (2) drive(0, 12'h000, 1, 0);
    drive(1, 12'hF00, 0, 0);                     // halt, then mova must wait
    repeat (3) drive(1, 12'h40C, 0, 0);
    drive(1, 12'h40C, 0, 1);
    drive(1, 12'h40C, 0, 0);
    repeat (2) drive(0, 12'h000, 0, 0);
    repeat (4) drive(1, 12'h001, 0, 0);          // illegal x4, counter saturates
    drive(1, 12'h4A5, 0, 0);
    repeat (2) drive(0, 12'h000, 0, 0);

    drive(1, 12'h8F2, 0, 0);                     // reset during second add step
    drive(0, 12'h000, 0, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_ctrl", ctl, 11'd0);
    chk("midrst_step", step, 0);
    chk("midrst_done", done, 0);
    chk("midrst_opnd", opnd, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_halted", halted, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("midrst_ready", ir_ready, 1);

    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 15);
      if (sel < 12) op = t_val[sel] | (8'($urandom) & ~t_mask[sel]);
      else          op = 8'($urandom);
      drive($urandom_range(0, 3) != 0, {op, 4'($urandom)}, 1'($urandom),
            $urandom_range(0, 7) == 0);
    end

    repeat (6) drive(0, 12'h000, 0, 1);
    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
